inst_fetch: RTL



---
 rtl/inst_fetch_if.sv | 36 +++
 rtl/inst_fetch.sv | 107 ++++++++++
 2 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-to-decode bundle plus the instruction-memory read port.
// Latency: pure wires; timing is owned by the producer and the memory.
// Backpressure: none in the bundle itself; stall/branch control travels as scalar ports.
interface inst_fetch_if #(
  parameter int INST_MEM_WIDTH = 2
);
  logic [INST_MEM_WIDTH-1:0] imem_addr;
  logic [31:0]               imem_data;
  logic [31:0]               inst;
  logic [INST_MEM_WIDTH-1:0] pc;
  logic [INST_MEM_WIDTH-1:0] pc1;
  logic                      distinct;
  logic                      inst_enable;

  // Fetch stage drives the memory address and the decode-facing fields.
  modport master (
    output imem_addr,
    input  imem_data,
    output inst,
    output pc,
    output pc1,
    output distinct,
    output inst_enable
  );

  // Memory/decode side sees the mirror image.
  modport slave (
    input  imem_addr,
    output imem_data,
    input  inst,
    input  pc,
    input  pc1,
    input  distinct,
    input  inst_enable
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: drives a sync-read imem, tracks the fetch PC, hands inst/pc/pc1 to decode.
// Latency: first instruction one cycle after start; branch target appears the next cycle (no bubbles).
// Backpressure: stall holds the presented instruction and re-reads its address; branch overrides stall.
module inst_fetch #(
  parameter int INST_MEM_WIDTH = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      halt,
  input  logic                      stall,
  input  logic                      branch_taken,
  input  logic [INST_MEM_WIDTH-1:0] branch_target,
  inst_fetch_if.master              fd,
  output logic [31:0]               fetch_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [INST_MEM_WIDTH-1:0] ONE = INST_MEM_WIDTH'(1);

  state_t                    state, state_nx;
  logic [INST_MEM_WIDTH-1:0] pc_f, pc_f_nx;   // next address to fetch
  logic [INST_MEM_WIDTH-1:0] pc_d, pc_d_nx;   // address of the word now on imem_data
  logic                      valid_d, valid_nx;
  logic                      deliver;

  // Decode-facing fields come straight from the data-phase registers and the memory.
  assign fd.inst        = fd.imem_data;
  assign fd.pc          = pc_d;
  assign fd.pc1         = pc_d + ONE;
  assign fd.inst_enable = (state == RUN) && (!stall || branch_taken);
  assign fd.distinct    = valid_d && !branch_taken;

  // A real instruction is handed over only in RUN, when decode captures and it is not squashed.
  assign deliver = (state == RUN) && fd.inst_enable && fd.distinct;

  // Memory address: redirect first, otherwise re-read the held word on stall so imem_data stays put.
  always_comb begin
    fd.imem_addr = '0;
    if (state == RUN) begin
      if (branch_taken)
        fd.imem_addr = branch_target;
      else if (stall)
        fd.imem_addr = pc_d;
      else
        fd.imem_addr = pc_f;
    end
  end

  // Next-state and PC update; halt beats branch beats stall beats advance.
  always_comb begin
    state_nx = state;
    pc_f_nx  = pc_f;
    pc_d_nx  = pc_d;
    valid_nx = valid_d;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          pc_d_nx  = '0;
          pc_f_nx  = ONE;
          valid_nx = 1'b1;
        end
      end
      RUN: begin
        if (halt) begin
          state_nx = IDLE;
          pc_d_nx  = '0;
          pc_f_nx  = '0;
          valid_nx = 1'b0;
        end else if (branch_taken) begin
          pc_d_nx  = branch_target;
          pc_f_nx  = branch_target + ONE;
          valid_nx = 1'b1;
        end else if (!stall) begin
          pc_d_nx  = pc_f;
          pc_f_nx  = pc_f + ONE;
          valid_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state       <= IDLE;
      pc_f        <= '0;
      pc_d        <= '0;
      valid_d     <= 1'b0;
      fetch_count <= '0;
    end else begin
      state   <= state_nx;
      pc_f    <= pc_f_nx;
      pc_d    <= pc_d_nx;
      valid_d <= valid_nx;
      if (deliver)
        fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule
